// File: rtl/m_lsu_ctrl_if.sv
// m_lsu_ctrl_if
//   Bundles the three handshakes of the M-stage load/store unit:
//     req_*  : pipeline -> LSU request (valid/ready)
//     bus_*  : LSU <-> word-addressed data bus (req/ack)
//     rsp_*  : LSU -> pipeline/CP0 one-cycle response
//   slave  : the view used by m_lsu_ctrl itself.
//   master : the view of everything around the unit (pipeline, bus and CP0).
//   ADDR_W : byte-address width; data paths are fixed at 32 bits.
interface m_lsu_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_byteen;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_exc;
  logic [4:0]        rsp_exccode;
  logic [ADDR_W-1:0] rsp_badaddr;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
           rsp_valid, rsp_data, rsp_exc, rsp_exccode, rsp_badaddr
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
           rsp_valid, rsp_data, rsp_exc, rsp_exccode, rsp_badaddr
  );
endinterface

// File: rtl/m_lsu_ctrl.sv
// m_lsu_ctrl
//   Sequential load/store unit for the M stage of the pipelined MIPS core.
//   Accepts one memory op per handshake, checks alignment, runs a single
//   word-addressed bus cycle with byte enables and waits (with timeout) for
//   bus_ack. Returns extended load data or an AdEL/AdES/DBE exception.
// Ports
//   clk    : clock, all state on the rising edge
//   reset  : synchronous, active-high
//   lsu    : m_lsu_ctrl_if.slave (request, bus and response signals)
// Parameters
//   ADDR_W   : byte-address width (must match the interface instance)
//   TO_CYC   : bus cycles without ack before DBE (>= 2)
//   EXC_ADEL / EXC_ADES / EXC_DBE : exception codes reported to CP0
module m_lsu_ctrl #(
  parameter int         ADDR_W   = 32,
  parameter int         TO_CYC   = 16,
  parameter logic [4:0] EXC_ADEL = 5'd4,
  parameter logic [4:0] EXC_ADES = 5'd5,
  parameter logic [4:0] EXC_DBE  = 5'd7
) (
  input logic         clk,
  input logic         reset,
  m_lsu_ctrl_if.slave lsu
);

  localparam int              CNT_W    = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH  = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SB  = 3'd6;
  localparam logic [2:0] OP_SH  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  state_t            state_reg;
  logic [2:0]        op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              bus_req_reg;
  logic              bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [3:0]        bus_byteen_reg;
  logic [31:0]       bus_wdata_reg;

  logic              rsp_valid_reg;
  logic [31:0]       rsp_data_reg;
  logic              rsp_exc_reg;
  logic [4:0]        rsp_exccode_reg;
  logic [ADDR_W-1:0] rsp_badaddr_reg;

  // ---------------------------------------------------------------------
  // Request decode: alignment, byte lanes and lane-replicated store data
  // ---------------------------------------------------------------------
  logic [1:0]  req_lo;
  logic        req_store;
  logic        req_misaligned;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata_lane;

  assign req_lo = lsu.req_addr[1:0];

  always_comb begin
    req_store      = 1'b0;
    req_misaligned = 1'b0;
    req_byteen     = 4'b0000;
    req_wdata_lane = 32'h0;
    case (lsu.req_op)
      OP_LW: begin
        req_misaligned = (req_lo != 2'b00);
        req_byteen     = 4'b1111;
      end
      OP_SW: begin
        req_store      = 1'b1;
        req_misaligned = (req_lo != 2'b00);
        req_byteen     = 4'b1111;
        req_wdata_lane = lsu.req_wdata;
      end
      OP_LH, OP_LHU: begin
        req_misaligned = req_lo[0];
        req_byteen     = 4'b0011 << {req_lo[1], 1'b0};
      end
      OP_SH: begin
        req_store      = 1'b1;
        req_misaligned = req_lo[0];
        req_byteen     = 4'b0011 << {req_lo[1], 1'b0};
        req_wdata_lane = {2{lsu.req_wdata[15:0]}};
      end
      OP_LB, OP_LBU: begin
        req_byteen     = 4'b0001 << req_lo;
      end
      OP_SB: begin
        req_store      = 1'b1;
        req_byteen     = 4'b0001 << req_lo;
        req_wdata_lane = {4{lsu.req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Load extraction from the returned word, using the latched op/address
  // ---------------------------------------------------------------------
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = lsu.bus_rdata[8*gi +: 8];
  end

  assign sel_byte = rd_byte[addr_reg[1:0]];
  assign sel_half = addr_reg[1] ? lsu.bus_rdata[31:16] : lsu.bus_rdata[15:0];

  always_comb begin
    load_data = 32'h0;
    case (op_reg)
      OP_LW:   load_data = lsu.bus_rdata;
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h0, sel_byte};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0, sel_half};
      default: load_data = 32'h0;  // stores return zero data
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered bus and response outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      op_reg          <= 3'd0;
      addr_reg        <= '0;
      cnt_reg         <= '0;
      bus_req_reg     <= 1'b0;
      bus_we_reg      <= 1'b0;
      bus_addr_reg    <= '0;
      bus_byteen_reg  <= 4'b0000;
      bus_wdata_reg   <= 32'h0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= 32'h0;
      rsp_exc_reg     <= 1'b0;
      rsp_exccode_reg <= 5'd0;
      rsp_badaddr_reg <= '0;
    end else begin
      // Response fields are a one-cycle pulse; zero them unless set below.
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= 32'h0;
      rsp_exc_reg     <= 1'b0;
      rsp_exccode_reg <= 5'd0;
      rsp_badaddr_reg <= '0;

      case (state_reg)
        ST_IDLE: begin
          // req_ready is implied here: IDLE and not in reset.
          if (lsu.req_valid) begin
            op_reg   <= lsu.req_op;
            addr_reg <= lsu.req_addr;
            cnt_reg  <= '0;
            if (req_misaligned) begin
              state_reg       <= ST_RESP;
              rsp_valid_reg   <= 1'b1;
              rsp_exc_reg     <= 1'b1;
              rsp_exccode_reg <= req_store ? EXC_ADES : EXC_ADEL;
              rsp_badaddr_reg <= lsu.req_addr;
            end else begin
              state_reg      <= ST_BUS;
              bus_req_reg    <= 1'b1;
              bus_we_reg     <= req_store;
              bus_addr_reg   <= {lsu.req_addr[ADDR_W-1:2], 2'b00};
              bus_byteen_reg <= req_byteen;
              bus_wdata_reg  <= req_wdata_lane;
            end
          end
        end

        ST_BUS: begin
          // Ack is tested first so that an ack in the timeout cycle wins.
          if (lsu.bus_ack || cnt_reg == CNT_LAST) begin
            state_reg      <= ST_RESP;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= '0;
            bus_byteen_reg <= 4'b0000;
            bus_wdata_reg  <= 32'h0;
            rsp_valid_reg  <= 1'b1;
            if (lsu.bus_ack) begin
              rsp_data_reg <= load_data;
            end else begin
              rsp_exc_reg     <= 1'b1;
              rsp_exccode_reg <= EXC_DBE;
              rsp_badaddr_reg <= addr_reg;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_RESP: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign lsu.req_ready   = (state_reg == ST_IDLE) && !reset;
  assign lsu.bus_req     = bus_req_reg;
  assign lsu.bus_we      = bus_we_reg;
  assign lsu.bus_addr    = bus_addr_reg;
  assign lsu.bus_byteen  = bus_byteen_reg;
  assign lsu.bus_wdata   = bus_wdata_reg;
  assign lsu.rsp_valid   = rsp_valid_reg;
  assign lsu.rsp_data    = rsp_data_reg;
  assign lsu.rsp_exc     = rsp_exc_reg;
  assign lsu.rsp_exccode = rsp_exccode_reg;
  assign lsu.rsp_badaddr = rsp_badaddr_reg;

endmodule

// File: tb/tb_m_lsu_ctrl.sv
// tb_m_lsu_ctrl
//   Directed bench for m_lsu_ctrl. Expected responses are queued when a
//   request is issued and compared by a monitor when rsp_valid pulses; bus
//   side fields and handshake timing are compared inline by the stimulus.
module tb_m_lsu_ctrl;

  localparam int ADDR_W = 32;
  localparam int TO_CYC = 16;

  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LB  = 3'd1;
  localparam logic [2:0] LBU = 3'd2;
  localparam logic [2:0] LH  = 3'd3;
  localparam logic [2:0] LHU = 3'd4;
  localparam logic [2:0] SW  = 3'd5;
  localparam logic [2:0] SB  = 3'd6;
  localparam logic [2:0] SH  = 3'd7;

  typedef struct {
    logic [31:0] data;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badaddr;
  } rsp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  m_lsu_ctrl_if #(.ADDR_W(ADDR_W)) lsu_if ();

  m_lsu_ctrl #(
    .ADDR_W  (ADDR_W),
    .TO_CYC  (TO_CYC),
    .EXC_ADEL(5'd4),
    .EXC_ADES(5'd5),
    .EXC_DBE (5'd7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .lsu  (lsu_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference extension: shift the addressed lane down, then extend.
  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> (8 * addr[1:0]);
    case (op)
      LW:      return rdata;
      LB:      return {{24{s[7]}}, s[7:0]};
      LBU:     return {24'h0, s[7:0]};
      LH:      return {{16{s[15]}}, s[15:0]};
      LHU:     return {16'h0, s[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Response monitor: pops one expectation per rsp_valid pulse.
  always @(negedge clk) begin
    if (lsu_if.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(lsu_if.rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", lsu_if.rsp_data, e.data);
        chk("rsp_exc", 32'(lsu_if.rsp_exc), 32'(e.exc));
        chk("rsp_exccode", 32'(lsu_if.rsp_exccode), 32'(e.code));
        chk("rsp_badaddr", lsu_if.rsp_badaddr, e.badaddr);
        $display("rsp: data=%08h exc=%0d code=%0d badaddr=%08h", lsu_if.rsp_data,
                 lsu_if.rsp_exc, lsu_if.rsp_exccode, lsu_if.rsp_badaddr);
      end
    end else begin
      chk("rsp_idle_zero", 32'(|{lsu_if.rsp_data, lsu_if.rsp_exc, lsu_if.rsp_exccode,
                                 lsu_if.rsp_badaddr}), 32'd0);
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (lsu_if.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(lsu_if.req_ready), 32'd1);
  endtask

  // One full transaction. ack_at = bus cycle (1-based) carrying bus_ack;
  // 0 or > TO_CYC means the bus never acknowledges.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_at, input logic [31:0] rdata, input string tag);
    logic       store, mis, acked;
    logic [3:0] be;
    logic [31:0] wd;
    rsp_t       e;
    store = (op >= SW);
    mis   = ((op == LW || op == SW) && addr[1:0] != 2'b00) ||
            ((op == LH || op == LHU || op == SH) && addr[0]);
    acked = (ack_at >= 1 && ack_at <= TO_CYC);
    case (op)
      LW, SW:       be = 4'hF;
      LH, LHU, SH:  be = addr[1] ? 4'hC : 4'h3;
      default:      be = 4'b0001 << addr[1:0];
    endcase
    case (op)
      SW:      wd = wdata;
      SH:      wd = {wdata[15:0], wdata[15:0]};
      default: wd = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
    endcase
    if (mis) begin
      e.data = 32'h0; e.exc = 1'b1; e.code = store ? 5'd5 : 5'd4; e.badaddr = addr;
    end else if (acked) begin
      e.data = store ? 32'h0 : exp_load(op, addr, rdata);
      e.exc = 1'b0; e.code = 5'd0; e.badaddr = 32'h0;
    end else begin
      e.data = 32'h0; e.exc = 1'b1; e.code = 5'd7; e.badaddr = addr;
    end

    wait_ready(tag);
    lsu_if.req_valid = 1'b1;
    lsu_if.req_op    = op;
    lsu_if.req_addr  = addr;
    lsu_if.req_wdata = wdata;
    exp_q.push_back(e);
    $display("req %s: op=%0d addr=%08h wdata=%08h ack_at=%0d rdata=%08h", tag, op, addr,
             wdata, ack_at, rdata);
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    lsu_if.req_op    = $urandom_range(0, 7);
    lsu_if.req_addr  = $urandom;

    if (mis) begin
      chk({tag, "_nobus"}, 32'(lsu_if.bus_req), 32'd0);
    end else begin
      for (int k = 1; k <= TO_CYC; k++) begin
        chk({tag, "_bus_req"}, 32'(lsu_if.bus_req), 32'd1);
        chk({tag, "_bus_we"}, 32'(lsu_if.bus_we), 32'(store));
        chk({tag, "_bus_addr"}, lsu_if.bus_addr, {addr[31:2], 2'b00});
        chk({tag, "_byteen"}, 32'(lsu_if.bus_byteen), 32'(be));
        if (store) chk({tag, "_bus_wdata"}, lsu_if.bus_wdata, wd);
        if (ack_at == k) begin
          lsu_if.bus_ack   = 1'b1;
          lsu_if.bus_rdata = rdata;
        end
        @(negedge clk);
        lsu_if.bus_ack   = 1'b0;
        lsu_if.bus_rdata = $urandom;
        if (ack_at == k) break;
      end
      chk({tag, "_bus_drop"}, 32'(lsu_if.bus_req), 32'd0);
    end
    chk({tag, "_rsp_latency"}, 32'(lsu_if.rsp_valid), 32'd1);
    chk({tag, "_resp_not_ready"}, 32'(lsu_if.req_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, 32'(lsu_if.rsp_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(lsu_if.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lsu_if.req_valid = 1'b0;
    lsu_if.req_op    = 3'd0;
    lsu_if.req_addr  = 32'h0;
    lsu_if.req_wdata = 32'h0;
    lsu_if.bus_ack   = 1'b0;
    lsu_if.bus_rdata = 32'h0;
    reset = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(lsu_if.req_ready), 32'd0);
    chk("reset_bus_req", 32'(lsu_if.bus_req), 32'd0);
    chk("reset_rsp_valid", 32'(lsu_if.rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(lsu_if.req_ready), 32'd1);

    // Loads with lane extraction and extension
    run_op(LB,  32'h0000_1003, 32'h0, 1, 32'h80FF_1234, "lb_b3");
    run_op(LBU, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, "lbu_b3");
    run_op(LB,  32'h0000_1001, 32'h0, 2, 32'h80FF_1234, "lb_b1");
    run_op(LHU, 32'h0000_1002, 32'h0, 2, 32'h80FF_1234, "lhu_h1");
    run_op(LH,  32'h0000_1002, 32'h0, 1, 32'h80FF_1234, "lh_h1");
    run_op(LH,  32'h0000_1000, 32'h0, 1, 32'h80FF_9234, "lh_h0");
    run_op(LW,  32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF, "lw");

    // Stores with lane replication
    run_op(SB, 32'h0000_2001, 32'h0000_00AB, 1, 32'h0, "sb");
    run_op(SH, 32'h0000_2002, 32'h1234_CAFE, 2, 32'h0, "sh");
    run_op(SW, 32'h0000_2000, 32'h1122_3344, 1, 32'h0, "sw");

    // Misalignment (and a byte op that must never be misaligned)
    run_op(LW,  32'h0000_3002, 32'h0, 1, 32'h0, "lw_misal");
    run_op(SH,  32'h0000_3001, 32'h5555_AAAA, 1, 32'h0, "sh_misal");
    run_op(LHU, 32'h0000_3003, 32'h0, 1, 32'h0, "lhu_misal");
    run_op(SW,  32'h0000_3001, 32'h0, 1, 32'h0, "sw_misal");
    run_op(SB,  32'h0000_3003, 32'h0000_0077, 1, 32'h0, "sb_b3");

    // Bus timeout and ack in the last allowed cycle
    run_op(SW, 32'h0000_5000, 32'hCAFE_F00D, 0, 32'h0, "sw_timeout");
    run_op(LW, 32'h0000_5004, 32'h0, TO_CYC, 32'h0BAD_CAFE, "lw_ack_last");
    run_op(SW, 32'h0000_5008, 32'h0, TO_CYC, 32'h0, "sw_ack_last");

    // Reset while waiting for the bus abandons the op
    wait_ready("rst_bus");
    lsu_if.req_valid = 1'b1;
    lsu_if.req_op    = LW;
    lsu_if.req_addr  = 32'h0000_4000;
    $display("req rst_bus: op=0 addr=00004000, reset asserted in bus cycle 1");
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    chk("rst_bus_req_before", 32'(lsu_if.bus_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_bus_req_after", 32'(lsu_if.bus_req), 32'd0);
    chk("rst_rsp_valid", 32'(lsu_if.rsp_valid), 32'd0);
    chk("rst_ready_low", 32'(lsu_if.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_high", 32'(lsu_if.req_ready), 32'd1);
    chk("rst_no_rsp", 32'(lsu_if.rsp_valid), 32'd0);

    // bus_ack outside BUS is ignored
    lsu_if.bus_ack   = 1'b1;
    lsu_if.bus_rdata = 32'h1357_9BDF;
    $display("idle ack: bus_ack held for 2 cycles with no request");
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_no_rsp", 32'(lsu_if.rsp_valid), 32'd0);
      chk("idle_ack_no_bus", 32'(lsu_if.bus_req), 32'd0);
    end
    lsu_if.bus_ack = 1'b0;

    run_op(LBU, 32'h0000_6002, 32'h0, 1, 32'h00C3_0000, "lbu_recover");

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
